cpu_peripheral_responder: RTL and testbench

- Peripheral-side responder for the CPU memory bus after it has been synchronised into the 2x domain.
- Accepts valid/address/write-data/strobes and decodes the address into one of REGIONS peripheral selects.
- Drives a one-cycle read or write strobe to the selected peripheral, waits for that peripheral's ready, then returns read data and a level ready.
- The ready is held until valid drops, so the crossing back to the 1x domain sees exactly one rising edge per transaction.

---
 rtl/cpu_peripheral_responder.sv | 144 ++++++++++++++
 tb/tb_cpu_peripheral_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_peripheral_responder.sv
// Peripheral-side responder for the 2x-domain CPU bus: decodes a region, strobes the peripheral,
// waits for its ready (bounded by a timeout) and holds a level ready until valid drops.
module cpu_peripheral_responder #(
  parameter int unsigned REGIONS      = 4,
  parameter int unsigned REGION_SHIFT = 20,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                      i_clk_2x,
  input  logic                      i_reset_n,
  input  logic                      i_cpu_mem_valid_2x,
  input  logic [23:0]               i_cpu_address_2x,
  input  logic [31:0]               i_cpu_write_data_2x,
  input  logic [3:0]                i_cpu_wstrb_2x,
  output logic                      o_cpu_mem_ready,
  output logic [31:0]               o_cpu_read_data,
  output logic [REGIONS-1:0]        o_periph_sel,
  output logic                      o_periph_we,
  output logic                      o_periph_re,
  output logic [REGION_SHIFT-1:0]   o_periph_address,
  output logic [31:0]               o_periph_write_data,
  output logic [3:0]                o_periph_wstrb,
  input  logic [32*REGIONS-1:0]     i_periph_read_data,
  input  logic [REGIONS-1:0]        i_periph_ready,
  output logic                      o_bus_error,
  input  logic                      i_bus_error_clear
);

  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e                    r_state;
  logic [CNTW-1:0]           r_cnt;
  logic [REGIONS-1:0]        r_sel;
  logic                      r_we;
  logic                      r_re;
  logic                      r_ready;
  logic                      r_bus_error;
  logic [31:0]               r_rdata;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic [REGION_SHIFT-1:0]   r_addr;

  logic [31:0]               w_region;
  logic                      w_mapped;
  logic [REGIONS-1:0]        w_onehot;
  logic                      w_ready;
  logic                      w_timeout;
  logic [31:0]               w_rdata;

  assign w_region  = 32'(i_cpu_address_2x[23:REGION_SHIFT]);
  assign w_mapped  = (w_region < REGIONS);
  // The latched one-hot select doubles as the region index for ready and data muxing.
  assign w_ready   = |(i_periph_ready & r_sel);
  assign w_timeout = (r_cnt == CNTW'(TIMEOUT));

  always_comb begin
    w_onehot = '0;
    w_rdata  = '0;
    for (int unsigned i = 0; i < REGIONS; i++) begin
      w_onehot[i] = (w_region == i);
      if (r_sel[i]) w_rdata = w_rdata | i_periph_read_data[32*i +: 32];
    end
  end

  always_ff @(posedge i_clk_2x or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_ready     <= 1'b0;
      r_bus_error <= 1'b0;
      r_rdata     <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_addr      <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      // Error sets below are later assignments, so a simultaneous set wins over clear.
      if (i_bus_error_clear) r_bus_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_cpu_mem_valid_2x) begin
            r_addr  <= i_cpu_address_2x[REGION_SHIFT-1:0];
            r_wdata <= i_cpu_write_data_2x;
            r_wstrb <= i_cpu_wstrb_2x;
            r_cnt   <= '0;
            if (w_mapped) begin
              r_sel   <= w_onehot;
              r_we    <= |i_cpu_wstrb_2x;
              r_re    <= ~|i_cpu_wstrb_2x;
              r_state <= StAccess;
            end else begin
              r_rdata     <= '0;
              r_bus_error <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= StRespond;
            end
          end
        end
        StAccess: begin
          if (w_ready || w_timeout) begin
            r_sel <= '0;
            if (w_ready) begin
              r_rdata <= w_rdata;
            end else begin
              r_rdata     <= '0;
              r_bus_error <= 1'b1;
            end
            if (i_cpu_mem_valid_2x) begin
              r_ready <= 1'b1;
              r_state <= StRespond;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        StRespond: begin
          if (!i_cpu_mem_valid_2x) begin
            r_ready <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cpu_mem_ready     = r_ready;
  assign o_cpu_read_data     = r_rdata;
  assign o_periph_sel        = r_sel;
  assign o_periph_we         = r_we;
  assign o_periph_re         = r_re;
  assign o_periph_address    = r_addr;
  assign o_periph_write_data = r_wdata;
  assign o_periph_wstrb      = r_wstrb;
  assign o_bus_error         = r_bus_error;

endmodule

// File: tb/tb_cpu_peripheral_responder.sv
// Directed bench for cpu_peripheral_responder; completions are checked against a scoreboard of
// expected read data and latency pushed when each request is driven.
module tb_cpu_peripheral_responder;

  localparam int unsigned REGIONS      = 4;
  localparam int unsigned REGION_SHIFT = 20;
  localparam int unsigned TIMEOUT      = 15;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    valid;
  logic [23:0]             addr;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    ready;
  logic [31:0]             rdata;
  logic [REGIONS-1:0]      sel;
  logic                    we;
  logic                    re;
  logic [REGION_SHIFT-1:0] paddr;
  logic [31:0]             pwdata;
  logic [3:0]              pwstrb;
  logic [32*REGIONS-1:0]   prdata;
  logic [REGIONS-1:0]      pready;
  logic                    berr;
  logic                    bclr;

  always #5 clk = ~clk;

  cpu_peripheral_responder #(
    .REGIONS     (REGIONS),
    .REGION_SHIFT(REGION_SHIFT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .i_clk_2x           (clk),
    .i_reset_n          (reset_n),
    .i_cpu_mem_valid_2x (valid),
    .i_cpu_address_2x   (addr),
    .i_cpu_write_data_2x(wdata),
    .i_cpu_wstrb_2x     (wstrb),
    .o_cpu_mem_ready    (ready),
    .o_cpu_read_data    (rdata),
    .o_periph_sel       (sel),
    .o_periph_we        (we),
    .o_periph_re        (re),
    .o_periph_address   (paddr),
    .o_periph_write_data(pwdata),
    .o_periph_wstrb     (pwstrb),
    .i_periph_read_data (prdata),
    .i_periph_ready     (pready),
    .o_bus_error        (berr),
    .i_bus_error_clear  (bclr)
  );

  typedef struct {
    logic [31:0] data;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rises  = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready === 1'b1 && prev_ready !== 1'b1) rises <= rises + 1;
    prev_ready <= ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] edata, input int lat);
    exp_t e;
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    e.data = edata;
    e.t0   = cyc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic expect_ready(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
    chk({tag, "_data"}, rdata, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n = 1'b0;
    valid   = 1'b0;
    addr    = '0;
    wdata   = '0;
    wstrb   = '0;
    pready  = '0;
    bclr    = 1'b0;
    prdata  = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h11111111};
    #1;
    chk("reset_ready", ready, 0);
    chk("reset_outs", {sel, we, re, berr, rdata}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Read, zero wait states
    pready = 4'b0010;
    start(24'h100010, 32'h0, 4'h0, 32'hCAFEF00D, 2);
    step();
    chk("rd_sel", sel, 4'b0010);
    chk("rd_strobes", {we, re}, 2'b01);
    chk("rd_addr", paddr, 20'h00010);
    chk("rd_ready_early", ready, 0);
    step();
    chk("rd_re_one_cycle", re, 0);
    chk("rd_sel_released", sel, 0);
    expect_ready("rd");
    step();
    chk("rd_ready_held", ready, 1);
    valid = 1'b0;
    step();
    chk("rd_ready_fall", ready, 0);
    chk("rd_data_hold_idle", rdata, 32'hCAFEF00D);

    // Write, three wait states; other regions' ready must be ignored
    pready = 4'b1011;
    start(24'h200004, 32'h12345678, 4'b0011, 32'h22222222, 5);
    step();
    chk("wr_strobes", {we, re}, 2'b10);
    chk("wr_sel", sel, 4'b0100);
    chk("wr_payload", {pwdata, pwstrb, paddr}, {32'h12345678, 4'b0011, 20'h00004});
    step();
    chk("wr_we_one_cycle", we, 0);
    step();
    step();
    chk("wr_sel_cycle4", sel, 4'b0100);
    chk("wr_no_ready_yet", ready, 0);
    pready = 4'b0100;
    expect_ready("wr");
    chk("wr_no_error", berr, 0);
    valid  = 1'b0;
    pready = '0;
    step();

    // Unmapped address
    start(24'h700000, 32'h0, 4'h0, 32'h0, 1);
    step();
    chk("um_no_strobes", {sel, we, re}, 0);
    expect_ready("um");
    chk("um_error", berr, 1);
    valid = 1'b0;
    step();
    bclr = 1'b1;
    step();
    bclr = 1'b0;
    chk("um_clear", berr, 0);
    start(24'hF00000, 32'h0, 4'h0, 32'h0, 1);
    bclr = 1'b1;
    step();
    bclr = 1'b0;
    chk("um_set_wins", berr, 1);
    expect_ready("um2");
    valid = 1'b0;
    step();
    bclr = 1'b1;
    step();
    bclr = 1'b0;

    // Back-to-back with one valid-low cycle
    pready = 4'b1001;
    rises  = 0;
    start(24'h000040, 32'h0, 4'h0, 32'h11111111, 2);
    expect_ready("b2b_a");
    valid = 1'b0;
    step();
    chk("b2b_ready_low", ready, 0);
    start(24'h300000, 32'h0, 4'h0, 32'h33333333, 2);
    step();
    chk("b2b_second_access", {ready, sel}, {1'b0, 4'b1000});
    expect_ready("b2b_b");
    valid = 1'b0;
    step();
    step();
    chk("b2b_rises", rises, 2);

    // Timeout on region 3
    pready = 4'b0111;
    start(24'h300000, 32'h0, 4'h0, 32'h0, TIMEOUT + 2);
    k = 0;
    step();
    while (sel === 4'b1000 && k < 40) begin
      k++;
      step();
    end
    chk("to_sel_cycles", k, TIMEOUT + 1);
    expect_ready("to");
    chk("to_error", berr, 1);
    valid = 1'b0;
    step();
    chk("to_error_sticky", berr, 1);
    bclr = 1'b1;
    step();
    bclr = 1'b0;
    chk("to_error_cleared", berr, 0);

    // Abort: valid dropped during ACCESS
    pready = 4'b0010;
    valid  = 1'b1;
    addr   = 24'h100000;
    wstrb  = 4'h0;
    step();
    chk("ab_access", sel, 4'b0010);
    valid = 1'b0;
    rises = 0;
    step();
    step();
    step();
    chk("ab_no_ready", rises, 0);
    chk("ab_data_captured", rdata, 32'hCAFEF00D);
    start(24'h000000, 32'h0, 4'h0, 32'h11111111, 2);
    pready = 4'b0001;
    expect_ready("ab_next");
    valid = 1'b0;
    step();

    // Reset during ACCESS
    pready = '0;
    start(24'h1ABCDE, 32'hAAAA5555, 4'hF, 32'hCAFEF00D, 3);
    step();
    chk("rs_in_access", {sel, we}, {4'b0010, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("rs_async_outs", {ready, sel, we, re, berr, rdata, pwdata, pwstrb, paddr}, 0);
    valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("rs_no_ready", ready, 0);
    sb.delete();
    pready = 4'b0010;
    start(24'h100008, 32'h0, 4'h0, 32'hCAFEF00D, 2);
    expect_ready("rs_next");
    valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
